// File: rtl/wb_slave_regbank.sv
// wb_slave_regbank: parametrised Wishbone B4 slave register bank.
// Registers can be written from the bus (lane-selective) or from the
// hardware update port (full word). All registers are exported on regs_o.
// Define WB_SLAVE_REGBANK_PIPELINED_EN for B4 pipelined mode (adds stall_o,
// one transfer per cycle); otherwise classic mode with a RESP cycle.
module wb_slave_regbank #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int GRANULE      = 8,
  parameter int REGISTER_NUM = 16,
  parameter logic [REGISTER_NUM*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [REGISTER_NUM-1:0]            RO_MASK     = '0,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            adr_i,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  output logic [DATA_WIDTH-1:0]            dat_o,
  input  logic [SEL_WIDTH-1:0]             sel_i,
  input  logic                             we_i,
  input  logic                             stb_i,
  input  logic                             cyc_i,
  output logic                             ack_o,
  output logic                             err_o,
`ifdef WB_SLAVE_REGBANK_PIPELINED_EN
  output logic                             stall_o,
`endif
  input  logic                             hw_we_i,
  input  logic [ADDR_WIDTH-1:0]            hw_idx_i,
  input  logic [DATA_WIDTH-1:0]            hw_dat_i,
  output logic [REGISTER_NUM*DATA_WIDTH-1:0] regs_o
);

  // Register count widened by one bit so REGISTER_NUM == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] REG_NUM_EXT = (ADDR_WIDTH+1)'(REGISTER_NUM);

`ifdef WB_SLAVE_REGBANK_PIPELINED_EN
  localparam bit PIPELINED = 1'b1;
`else
  localparam bit PIPELINED = 1'b0;
`endif

  typedef enum logic {IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [REGISTER_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_NUM];
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  busReq;
  logic                  accept;
  logic                  adrValid;
  logic                  hwValid;
  logic                  roHit;
  logic                  busErr;
  logic [DATA_WIDTH-1:0] selMask;
  logic [DATA_WIDTH-1:0] readWord;

  // Expand the lane selects into a bit mask over the data word.
  function automatic logic [DATA_WIDTH-1:0] laneMask(input logic [SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      m[i*GRANULE +: GRANULE] = {GRANULE{sel[i]}};
    end
    return m;
  endfunction

  // Decode the request, apply hardware then bus writes, and build the response.
  always_comb begin
    state_d  = IDLE;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    regs_d   = regs_q;
    readWord = '0;
    roHit    = 1'b0;

    busReq   = cyc_i & stb_i;
    accept   = busReq && (PIPELINED || (state_q == IDLE));
    adrValid = ({1'b0, adr_i} < REG_NUM_EXT);
    hwValid  = hw_we_i && ({1'b0, hw_idx_i} < REG_NUM_EXT);
    selMask  = laneMask(sel_i);

    for (int n = 0; n < REGISTER_NUM; n++) begin
      if (adr_i == ADDR_WIDTH'(n)) begin
        readWord = regs_q[n];
        roHit    = RO_MASK[n];
      end
      if (hwValid && (hw_idx_i == ADDR_WIDTH'(n))) begin
        regs_d[n] = hw_dat_i;
      end
    end

    busErr = !adrValid || (we_i && roHit);

    if (accept) begin
      if (!PIPELINED) begin
        state_d = RESP;
      end
      if (busErr) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (we_i) begin
          for (int n = 0; n < REGISTER_NUM; n++) begin
            if (adr_i == ADDR_WIDTH'(n)) begin
              regs_d[n] = (regs_d[n] & ~selMask) | (dat_i & selMask);
            end
          end
        end else begin
          dat_d = readWord & selMask;
        end
      end
    end
  end

  // State, response and register storage with synchronous reset to the reset image.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      for (int n = 0; n < REGISTER_NUM; n++) begin
        regs_q[n] <= RESET_VALUE[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar g = 0; g < REGISTER_NUM; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;
`ifdef WB_SLAVE_REGBANK_PIPELINED_EN
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Self-checking bench for wb_slave_regbank: directed scenarios plus random
// traffic, checked by a scoreboard fed from a behavioural register-file model.
module tb_wb_slave_regbank;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int NREG = 16;
   localparam logic [NREG*DW-1:0] RV = {320'h0, 32'h5A5A5A5A, 32'hCAFEF00D,
                                       32'hDEADBEEF, 32'hAABBCCDD,
                                       32'h00000000, 32'h01010101};
   localparam logic [NREG-1:0] RO = 16'h0220;
`ifdef WB_SLAVE_REGBANK_PIPELINED_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   typedef struct {
      bit          isErr;
      bit          checkData;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk, rst, cyc, stb, we, ack, err, stall, hwWe;
   logic [AW-1:0] adr, hwIdx;
   logic [DW-1:0] datIn, datOut, hwDat;
   logic [3:0] sel;
   logic [NREG*DW-1:0] regsOut;

   int tests = 0;
   int fails = 0;
   int cycleCount = 0;
   int ackCount = 0;
   exp_t scoreQ[$];
   exp_t front;

   logic [31:0] modelRegs [NREG];
   logic [31:0] nextRegs [NREG];
   bit          busy;
   logic [31:0] lastDat;

   wb_slave_regbank #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .REGISTER_NUM(NREG),
      .RESET_VALUE(RV), .RO_MASK(RO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(datIn), .dat_o(datOut),
      .sel_i(sel), .we_i(we), .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .err_o(err),
`ifdef WB_SLAVE_REGBANK_PIPELINED_EN
      .stall_o(stall),
`endif
      .hw_we_i(hwWe), .hw_idx_i(hwIdx), .hw_dat_i(hwDat), .regs_o(regsOut)
   );

`ifndef WB_SLAVE_REGBANK_PIPELINED_EN
   assign stall = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index used to time-stamp when each response is due.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] maskOf(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   // Monitor: every response must match the oldest expectation and arrive in its due cycle.
   always @(negedge clk) begin
      if (scoreQ.size() > 0 && scoreQ[0].due == cycleCount) begin
         front = scoreQ.pop_front();
         checkOutput("resp_ack", 64'(ack), 64'(!front.isErr));
         checkOutput("resp_err", 64'(err), 64'(front.isErr));
         if (front.checkData) checkOutput("resp_data", 64'(datOut), 64'(front.data));
      end else if (ack || err) begin
         checkOutput("unexpected_resp", {62'b0, ack, err}, 64'b0);
      end
      if (ack) ackCount++;
   end

   // Drive one cycle of inputs, predict the slave's reaction, then compare regs_o.
   task automatic applyStimulus(input bit iRst, input bit iCyc, input bit iStb, input bit iWe,
                                input logic [15:0] iAdr, input logic [31:0] iDat, input logic [3:0] iSel,
                                input bit iHwWe, input logic [15:0] iHwIdx, input logic [31:0] iHwDat);
      logic [31:0] m;
      logic [NREG*DW-1:0] flat;
      bit acc, bad;
      exp_t e;
      @(negedge clk);
      rst = iRst; cyc = iCyc; stb = iStb; we = iWe; adr = iAdr; datIn = iDat;
      sel = iSel; hwWe = iHwWe; hwIdx = iHwIdx; hwDat = iHwDat;
      flat = RV;
      if (iRst) begin
         for (int n = 0; n < NREG; n++) nextRegs[n] = flat[n*DW +: DW];
         busy = 0;
         lastDat = '0;
      end else begin
         for (int n = 0; n < NREG; n++) nextRegs[n] = modelRegs[n];
         if (iHwWe && iHwIdx < NREG) nextRegs[iHwIdx[3:0]] = iHwDat;
         acc = iCyc && iStb && (PIPE || !busy);
         busy = acc && !PIPE;
         if (acc) begin
            bad = (iAdr >= NREG) || (iWe && RO[iAdr[3:0]]);
            m = maskOf(iSel);
            e.due = cycleCount + 1;
            e.isErr = bad;
            e.checkData = 1;
            e.data = lastDat;
            if (!bad && iWe) begin
               nextRegs[iAdr[3:0]] = (nextRegs[iAdr[3:0]] & ~m) | (iDat & m);
               e.checkData = 0;
            end else if (!bad) begin
               lastDat = modelRegs[iAdr[3:0]] & m;
               e.data = lastDat;
            end
            scoreQ.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < NREG; n++) begin
         modelRegs[n] = nextRegs[n];
         flat[n*DW +: DW] = nextRegs[n];
      end
      tests++;
      if (regsOut !== flat) begin
         fails++;
         $display("[TB] FAIL regs_o: got %h expected %h", regsOut, flat);
      end
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 16'd0, 32'd0, 4'h0, 0, 16'd0, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acksBefore;
      bit rCyc, rStb, rWe, rHw, rRst;
      logic [15:0] rAdr, rHwIdx;
      rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; datIn = '0; sel = '0;
      hwWe = 0; hwIdx = '0; hwDat = '0; busy = 0; lastDat = '0;
      for (int n = 0; n < NREG; n++) modelRegs[n] = '0;

      applyStimulus(1, 0, 0, 0, 16'd0, 32'd0, 4'h0, 0, 16'd0, 32'd0);
      applyStimulus(1, 0, 0, 0, 16'd0, 32'd0, 4'h0, 0, 16'd0, 32'd0);
      checkOutput("reset_ack", 64'(ack), 64'd0);
      checkOutput("reset_err", 64'(err), 64'd0);
      checkOutput("reset_dat", 64'(datOut), 64'd0);
      checkOutput("reset_stall", 64'(stall), 64'd0);
      idle();

      // Reset value readback
      applyStimulus(0, 1, 1, 0, 16'd3, 32'd0, 4'hF, 0, 16'd0, 32'd0);
      checkOutput("read_reg3", 64'(datOut), 64'h0000_0000_DEADBEEF);
      idle();

      // Partial-lane write
      applyStimulus(0, 1, 1, 1, 16'd2, 32'h11223344, 4'b0101, 0, 16'd0, 32'd0);
      idle();
      applyStimulus(0, 1, 1, 0, 16'd2, 32'd0, 4'hF, 0, 16'd0, 32'd0);
      checkOutput("read_reg2", 64'(datOut), 64'h0000_0000_AA22CC44);
      checkOutput("regs_o_2", 64'(regsOut[2*DW +: DW]), 64'h0000_0000_AA22CC44);
      idle();

      // Out-of-range read and read-only write
      applyStimulus(0, 1, 1, 0, 16'd16, 32'd0, 4'hF, 0, 16'd0, 32'd0);
      checkOutput("oob_err", 64'(err), 64'd1);
      checkOutput("oob_ack", 64'(ack), 64'd0);
      idle();
      applyStimulus(0, 1, 1, 1, 16'd5, 32'h0, 4'hF, 0, 16'd0, 32'd0);
      checkOutput("ro_err", 64'(err), 64'd1);
      idle();
      checkOutput("ro_unchanged", 64'(regsOut[5*DW +: DW]), 64'h0000_0000_5A5A5A5A);

      // Bus and hardware write collide on register 1
      applyStimulus(0, 1, 1, 1, 16'd1, 32'h000000FF, 4'b0001, 1, 16'd1, 32'h12345678);
      idle();
      checkOutput("collision", 64'(regsOut[1*DW +: DW]), 64'h0000_0000_123456FF);

      // Back-to-back reads with strobe held
      acksBefore = ackCount;
      for (int k = 0; k < 4; k++)
         applyStimulus(0, 1, 1, 0, 16'(k), 32'd0, 4'hF, 0, 16'd0, 32'd0);
      idle();
      idle();
      checkOutput("b2b_acks", 64'(ackCount - acksBefore), PIPE ? 64'd4 : 64'd2);

      // Abort followed by reset during the response cycle
      applyStimulus(0, 1, 1, 1, 16'd4, 32'h0, 4'hF, 0, 16'd0, 32'd0);
      applyStimulus(1, 0, 0, 0, 16'd0, 32'd0, 4'h0, 0, 16'd0, 32'd0);
      checkOutput("abort_ack", 64'(ack), 64'd0);
      checkOutput("abort_err", 64'(err), 64'd0);
      checkOutput("abort_reg4", 64'(regsOut[4*DW +: DW]), 64'h0000_0000_CAFEF00D);
      idle();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         rCyc = ($urandom_range(0, 7) != 0);
         rStb = 1'($urandom_range(0, 1));
         rWe = 1'($urandom_range(0, 1));
         rAdr = 16'($urandom_range(0, 17));
         rHw = ($urandom_range(0, 3) == 0);
         rHwIdx = ($urandom_range(0, 2) == 0) ? rAdr : 16'($urandom_range(0, 17));
         rRst = ($urandom_range(0, 99) == 0);
         applyStimulus(rRst, rCyc, rStb, rWe, rAdr, $urandom, 4'($urandom_range(0, 15)),
                       rHw, rHwIdx, $urandom);
      end
      idle();
      idle();
      idle();
      checkOutput("queue_drained", 64'(scoreQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
